// File: rtl/bowl_pkg.sv
// -----------------------------------------------------------------------------
// bowl_pkg
// Shared definitions for the bowling score keeper: game geometry defaults,
// the maximum attainable score and the roll-position state encoding.
// -----------------------------------------------------------------------------
package bowl_pkg;

    localparam int PINS_DEF    = 10;   // pins per rack
    localparam int FRAMES_DEF  = 10;   // frames per game
    localparam int SCORE_W_DEF = 11;   // width of the running total
    localparam int MAX_SCORE   = 300;  // perfect game

    // Position within the game. S_X2/S_X3 only exist in the final frame.
    typedef enum logic [2:0] {
        S_R1,    // first roll of a frame
        S_R2,    // second roll of an open first ball
        S_X2,    // final frame, second roll after a strike
        S_X3,    // final frame, fill ball
        S_DONE   // game complete, rolls ignored
    } state_e;

endpackage

// File: rtl/bowling_score_keeper_if.sv
// -----------------------------------------------------------------------------
// bowling_score_keeper_if
// Roll input / score output bundle between lane input logic and the scorer.
//   roll_valid  single-cycle strobe, roll_pins holds a new roll
//   roll_pins   pins knocked down this roll
//   point       running game total (feeds OutReg7Seg)
//   frame_no    current frame 1..FRAMES
//   roll_no     roll within the frame 1..3
//   score_upd   pulse, a roll was accepted
//   illegal     pulse, a roll was rejected (or clamped)
//   game_over   level, the last roll of the game has been accepted
// master: roll source.  slave: score keeper.
// -----------------------------------------------------------------------------
interface bowling_score_keeper_if
    import bowl_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
);
    logic               roll_valid;
    logic [3:0]         roll_pins;
    logic [SCORE_W-1:0] point;
    logic [3:0]         frame_no;
    logic [1:0]         roll_no;
    logic               score_upd;
    logic               illegal;
    logic               game_over;

    modport master (
        output roll_valid, roll_pins,
        input  point, frame_no, roll_no, score_upd, illegal, game_over
    );

    modport slave (
        input  roll_valid, roll_pins,
        output point, frame_no, roll_no, score_upd, illegal, game_over
    );
endinterface

// File: rtl/bowl_roll_check.sv
// -----------------------------------------------------------------------------
// bowl_roll_check
// Combinational legality check and clamp for one roll.
//   state_i      current roll position
//   standing_i   pins still standing (meaningful in S_R2 / S_X3)
//   roll_pins_i  raw pin count from the lane
//   legal_o      roll fits the current rack
//   eff_pins_o   pin count to score (clamped to the rack when CLAMP_EN)
//   is_strike_o  full rack on a first ball (S_R1) or on a fresh rack in S_X2
//   is_spare_o   second ball clears the rack (S_R2)
// -----------------------------------------------------------------------------
module bowl_roll_check
    import bowl_pkg::*;
#(
    parameter int PINS     = PINS_DEF,
    parameter bit CLAMP_EN = 1'b0
) (
    input  state_e     state_i,
    input  logic [3:0] standing_i,
    input  logic [3:0] roll_pins_i,
    output logic       legal_o,
    output logic [3:0] eff_pins_o,
    output logic       is_strike_o,
    output logic       is_spare_o
);

    localparam logic [3:0] PINS_L = 4'(PINS);

    logic [3:0] max_pins;

    // Largest legal count: a fresh rack in S_R1/S_X2, whatever is left otherwise.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        max_pins = PINS_L;
        case (state_i)
            S_R2, S_X3: max_pins = standing_i;
            default:    max_pins = PINS_L;
        endcase
    end

    assign legal_o     = (roll_pins_i <= max_pins);
    assign eff_pins_o  = (legal_o || !CLAMP_EN) ? roll_pins_i : max_pins;
    assign is_strike_o = ((state_i == S_R1) || (state_i == S_X2)) && (eff_pins_o == PINS_L);
    assign is_spare_o  = (state_i == S_R2) && (eff_pins_o == standing_i);

endmodule

// File: rtl/bowling_score_keeper.sv
// -----------------------------------------------------------------------------
// bowling_score_keeper
// Tracks frame / roll position, applies strike and spare bonuses and holds the
// running game total.
//   clk   system clock, all state on the rising edge
//   rst   synchronous, active-high reset (wins over a roll in the same cycle)
//   bus   slave side of bowling_score_keeper_if (roll in, score/status out)
// A roll strobed on edge N is captured into an input register; the score,
// position and pulses it produces are updated on edge N+1. Strobes may come
// every cycle.
// Optional build macro BOWL_ILLEGAL_CLAMP_EN: an illegal roll is clamped to the
// current legal maximum and scored (illegal and score_upd both pulse). Without
// it an illegal roll changes nothing and only illegal pulses.
// -----------------------------------------------------------------------------
module bowling_score_keeper
    import bowl_pkg::*;
#(
    parameter int PINS    = PINS_DEF,
    parameter int FRAMES  = FRAMES_DEF,
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    bowling_score_keeper_if.slave  bus
);

`ifdef BOWL_ILLEGAL_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [3:0] PINS_L   = 4'(PINS);
    localparam logic [3:0] LAST_FRM = 4'(FRAMES);

    // Input capture stage
    logic       in_v_q;
    logic [3:0] in_pins_q;

    // Game state
    state_e             state_q;
    logic [3:0]         frame_q;
    logic [1:0]         roll_q;
    logic [3:0]         standing_q;
    logic [1:0]         pend_a_q;   // bonus weight for the next roll, 0..2
    logic               pend_b_q;   // bonus weight for the roll after, 0..1
    logic [SCORE_W-1:0] point_q;
    logic               upd_q;
    logic               ill_q;
    logic               over_q;

    // Roll evaluation
    logic               legal;
    logic [3:0]         eff_pins;
    logic               is_strike;
    logic               is_spare;
    logic               live;
    logic               accept;
    logic               reject;
    logic               last_frame;
    logic [SCORE_W-1:0] eff_w;
    logic [SCORE_W-1:0] point_d;

    bowl_roll_check #(
        .PINS     (PINS),
        .CLAMP_EN (CLAMP_EN)
    ) u_roll_check (
        .state_i     (state_q),
        .standing_i  (standing_q),
        .roll_pins_i (in_pins_q),
        .legal_o     (legal),
        .eff_pins_o  (eff_pins),
        .is_strike_o (is_strike),
        .is_spare_o  (is_spare)
    );

    assign live       = in_v_q && (state_q != S_DONE);
    assign accept     = live && (legal || CLAMP_EN);
    assign reject     = live && !legal;
    assign last_frame = (frame_q == LAST_FRM);

    // pins * (1 + pend_a) with pend_a in 0..2, built from shifts and adds.
    assign eff_w   = SCORE_W'(eff_pins);
    assign point_d = point_q + eff_w
                   + (pend_a_q[0] ? eff_w        : '0)
                   + (pend_a_q[1] ? (eff_w << 1) : '0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            in_v_q    <= 1'b0;
            in_pins_q <= '0;
        end else begin
            in_v_q    <= bus.roll_valid;
            in_pins_q <= bus.roll_pins;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is just the highest-priority branch
        // of the clocked block rather than part of the sensitivity list.
        if (rst) begin
            state_q    <= S_R1;
            frame_q    <= 4'd1;
            roll_q     <= 2'd1;
            standing_q <= PINS_L;
            pend_a_q   <= 2'd0;
            pend_b_q   <= 1'b0;
            point_q    <= '0;
            upd_q      <= 1'b0;
            ill_q      <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            upd_q <= accept;
            ill_q <= reject;

            if (accept) begin
                point_q <= point_d;

                // Bonuses are only earned in frames before the last one.
                if (!last_frame && (is_strike || is_spare)) begin
                    pend_a_q <= {1'b0, pend_b_q} + 2'd1;
                    pend_b_q <= is_strike;
                end else begin
                    pend_a_q <= {1'b0, pend_b_q};
                    pend_b_q <= 1'b0;
                end

                case (state_q)
                    S_R1: begin
                        if (is_strike) begin
                            if (last_frame) begin
                                state_q <= S_X2;
                                roll_q  <= 2'd2;
                            end else begin
                                frame_q <= frame_q + 4'd1;
                            end
                        end else begin
                            standing_q <= PINS_L - eff_pins;
                            state_q    <= S_R2;
                            roll_q     <= 2'd2;
                        end
                    end
                    S_R2: begin
                        if (!last_frame) begin
                            frame_q    <= frame_q + 4'd1;
                            state_q    <= S_R1;
                            roll_q     <= 2'd1;
                            standing_q <= PINS_L;
                        end else if (is_spare) begin
                            state_q    <= S_X3;
                            roll_q     <= 2'd3;
                            standing_q <= PINS_L;
                        end else begin
                            state_q <= S_DONE;
                            over_q  <= 1'b1;
                        end
                    end
                    S_X2: begin
                        // A second strike re-racks; otherwise the fill ball
                        // faces what is left.
                        standing_q <= is_strike ? PINS_L : (PINS_L - eff_pins);
                        state_q    <= S_X3;
                        roll_q     <= 2'd3;
                    end
                    S_X3: begin
                        state_q <= S_DONE;
                        over_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.point     = point_q;
    assign bus.frame_no  = frame_q;
    assign bus.roll_no   = roll_q;
    assign bus.score_upd = upd_q;
    assign bus.illegal   = ill_q;
    assign bus.game_over = over_q;

endmodule

// File: tb/tb_bowling_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_bowling_score_keeper
// Self-checking bench: directed games plus randomized games, compared against a
// frame-by-frame bowling score model computed from the list of accepted rolls.
// -----------------------------------------------------------------------------
module tb_bowling_score_keeper;
    import bowl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bowling_score_keeper_if #(.SCORE_W(11)) bus ();

    bowling_score_keeper #(
        .PINS    (10),
        .FRAMES  (10),
        .SCORE_W (11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;

    // Counts score_upd pulses seen on rising edges.
    always @(posedge clk) begin
        if (bus.score_upd === 1'b1) upd_cnt <= upd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int acc[$];           // accepted rolls of the current game
    int m_score, m_frame, m_roll, m_stand;
    bit m_done;

    function automatic int at(input int k);
        return (k < acc.size()) ? acc[k] : 0;
    endfunction

    // Classic frame scoring; bonuses only count rolls already thrown, which is
    // exactly the running total.
    function automatic void model_eval();
        int n = acc.size();
        int i = 0;
        int s, m;
        m_score = 0;
        m_done  = 0;
        for (int f = 1; f <= 9; f++) begin
            if (i >= n) begin
                m_frame = f; m_roll = 1; m_stand = 10;
                return;
            end
            if (acc[i] == 10) begin
                m_score += 10 + at(i + 1) + at(i + 2);
                i += 1;
            end else begin
                if (i + 1 >= n) begin
                    m_frame = f; m_roll = 2; m_stand = 10 - acc[i];
                    m_score += acc[i];
                    return;
                end
                s = acc[i] + acc[i + 1];
                m_score += s + ((s == 10) ? at(i + 2) : 0);
                i += 2;
            end
        end
        m_frame = 10;
        m = n - i;
        for (int k = i; k < n; k++) m_score += acc[k];
        m_roll = 1; m_stand = 10;
        if (m == 1) begin
            m_roll  = 2;
            m_stand = (acc[i] == 10) ? 10 : 10 - acc[i];
        end else if (m == 2) begin
            if (acc[i] == 10) begin
                m_roll  = 3;
                m_stand = (acc[i + 1] == 10) ? 10 : 10 - acc[i + 1];
            end else if (acc[i] + acc[i + 1] == 10) begin
                m_roll  = 3;
                m_stand = 10;
            end else begin
                m_done = 1;
            end
        end else if (m >= 3) begin
            m_done = 1;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input bit with_roll);
        @(negedge clk);
        rst            = 1'b1;
        bus.roll_valid = with_roll;
        bus.roll_pins  = 4'd10;
        @(negedge clk);
        rst            = 1'b0;
        bus.roll_valid = 1'b0;
        acc.delete();
        @(negedge clk);
    endtask

    // One isolated roll, then every output compared with the model.
    task automatic roll(input int pins);
        int exp_ill, exp_upd;
        model_eval();
        exp_ill = 0;
        exp_upd = 0;
        if (!m_done) begin
            if (pins <= m_stand) begin
                acc.push_back(pins);
                exp_upd = 1;
            end else begin
                exp_ill = 1;
`ifdef BOWL_ILLEGAL_CLAMP_EN
                acc.push_back(m_stand);
                exp_upd = 1;
`endif
            end
        end
        @(negedge clk);
        bus.roll_valid = 1'b1;
        bus.roll_pins  = pins[3:0];
        @(negedge clk);
        bus.roll_valid = 1'b0;
        @(negedge clk);
        model_eval();
        check("point",     bus.point,     m_score);
        check("illegal",   bus.illegal,   exp_ill);
        check("score_upd", bus.score_upd, exp_upd);
        check("game_over", bus.game_over, m_done);
        check("frame_no",  bus.frame_no,  m_frame);
        if (!m_done) check("roll_no", bus.roll_no, m_roll);
    endtask

    // Legal rolls strobed on consecutive cycles until the game ends.
    task automatic burst_game();
        int c0, pins;
        do_reset(1'b0);
        c0 = upd_cnt;
        for (int r = 0; r < 25; r++) begin
            model_eval();
            if (m_done) break;
            pins = $urandom_range(0, m_stand);
            acc.push_back(pins);
            @(negedge clk);
            bus.roll_valid = 1'b1;
            bus.roll_pins  = pins[3:0];
        end
        @(negedge clk);
        bus.roll_valid = 1'b0;
        @(negedge clk);
        model_eval();
        check("burst_point",     bus.point,     m_score);
        check("burst_game_over", bus.game_over, m_done);
        check("burst_frame_no",  bus.frame_no,  m_frame);
        repeat (3) @(negedge clk);
        check("burst_upd_count", upd_cnt - c0, acc.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0, pins;
        rst            = 1'b1;
        bus.roll_valid = 1'b0;
        bus.roll_pins  = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_point",     bus.point,     0);
        check("rst_frame_no",  bus.frame_no,  1);
        check("rst_roll_no",   bus.roll_no,   1);
        check("rst_score_upd", bus.score_upd, 0);
        check("rst_illegal",   bus.illegal,   0);
        check("rst_game_over", bus.game_over, 0);

        // Perfect game
        do_reset(1'b0);
        repeat (11) roll(10);
        check("perfect_roll_no_last", bus.roll_no, 3);
        roll(10);
        check("perfect_point", bus.point, MAX_SCORE);
        check("perfect_over",  bus.game_over, 1);
        roll(10);
        check("perfect_13th_illegal", bus.illegal, 0);
        check("perfect_13th_point",   bus.point, 300);

        // Gutter game
        do_reset(1'b0);
        c0 = upd_cnt;
        repeat (20) roll(0);
        check("gutter_point", bus.point, 0);
        check("gutter_over",  bus.game_over, 1);
        repeat (3) @(negedge clk);
        check("gutter_upd_count", upd_cnt - c0, 20);

        // All spares
        do_reset(1'b0);
        repeat (20) roll(5);
        check("spares_roll_no_fill", bus.roll_no, 3);
        check("spares_over_before",  bus.game_over, 0);
        roll(5);
        check("spares_point", bus.point, 150);
        check("spares_over",  bus.game_over, 1);

        // Open game, no fill ball
        do_reset(1'b0);
        repeat (9) begin roll(9); roll(0); end
        roll(3);
        roll(4);
        check("open_point", bus.point, 88);
        check("open_over",  bus.game_over, 1);
        roll(5);
        check("open_extra_point", bus.point, 88);
        check("open_extra_upd",   bus.score_upd, 0);

        // Illegal second ball
        do_reset(1'b0);
        roll(7);
        roll(5);
        check("ill_pulse", bus.illegal, 1);
`ifdef BOWL_ILLEGAL_CLAMP_EN
        check("ill_point",    bus.point, 10);
        check("ill_frame_no", bus.frame_no, 2);
        roll(3);
        check("ill_next_point", bus.point, 16);
`else
        check("ill_point",   bus.point, 7);
        check("ill_roll_no", bus.roll_no, 2);
        roll(3);
        check("ill_next_point",    bus.point, 10);
        check("ill_next_frame_no", bus.frame_no, 2);
`endif

        // Reset mid-game with a coincident roll
        do_reset(1'b0);
        repeat (3) roll(10);
        check("mid_point_before", bus.point, 60);
        do_reset(1'b1);
        check("mid_rst_point",    bus.point, 0);
        check("mid_rst_frame_no", bus.frame_no, 1);
        check("mid_rst_roll_no",  bus.roll_no, 1);
        check("mid_rst_upd",      bus.score_upd, 0);
        roll(4);
        check("mid_after_point", bus.point, 4);

        // Random games with occasional illegal counts
        for (int g = 0; g < 20; g++) begin
            do_reset(1'b0);
            for (int r = 0; r < 40; r++) begin
                model_eval();
                if (m_done) break;
                if ($urandom_range(0, 5) == 0)
                    pins = $urandom_range(m_stand + 1, 15);
                else
                    pins = $urandom_range(0, m_stand);
                roll(pins);
            end
            roll($urandom_range(0, 10));
        end

        // Back-to-back strobes
        repeat (6) burst_game();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bowling_score_keeper.md
Name: bowling_score_keeper

Overview:
Upstream scoring stage of the bowling display path. Consumes one pin-count per roll from the lane input logic. Tracks frame and roll position, applies strike and spare bonuses, and holds the running game total on `point`. `point` feeds OutReg7Seg directly, which splits it into hundreds, tens and units 7-segment codes.

Parameters:
PINS, 10, number of pins per rack; defines strike and spare and the legality limit.
FRAMES, 10, frames per game; frame FRAMES carries the fill-ball rules.
SCORE_W, 11, width of `point`; must hold 300, the maximum score.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
roll_valid  input  1  single-cycle strobe: roll_pins holds a new roll
roll_pins  input  4  pins knocked down this roll, legal range 0..PINS
point  output  SCORE_W  running game total, registered, drives OutReg7Seg
frame_no  output  4  current frame, 1..FRAMES
roll_no  output  2  roll within frame: 1, 2, or 3 (frame FRAMES only)
score_upd  output  1  one-cycle pulse, the cycle after an accepted roll
illegal  output  1  one-cycle pulse, the cycle after a rejected roll
game_over  output  1  high once the last roll of the game is accepted

Behaviour:
- One clock (`clk`). Reset is synchronous and active-high (`rst`). Reset has priority over `roll_valid` in the same cycle. Reset mid-game discards all progress.
- Reset values: point=0, frame_no=1, roll_no=1, score_upd=0, illegal=0, game_over=0, state=S_R1, pend_a=0, pend_b=0, standing=PINS.
- Latency: roll sampled on edge N; point, frame_no, roll_no, game_over and pulses are valid after edge N+1. Back-to-back strobes every cycle are supported.
- State machine:
  - S_R1: first roll of a frame. Strike: frames <FRAMES advance to the next frame's S_R1; frame FRAMES goes to S_X2. Otherwise standing=PINS-pins and go to S_R2.
  - S_R2: second roll, legal if pins<=standing. Frame <FRAMES: next frame S_R1. Frame FRAMES: spare goes to S_X3 with standing=PINS; open goes to S_DONE.
  - S_X2: frame FRAMES second roll after a strike, legal 0..PINS. If pins==PINS, standing=PINS; else standing=PINS-pins. Go to S_X3.
  - S_X3: fill ball, legal if pins<=standing. Go to S_DONE.
  - S_DONE: game_over=1. All further rolls are ignored with no illegal pulse. Only rst leaves S_DONE.
- Scoring uses bonus counters. pend_a (0..2) is the bonus weight for the next roll; pend_b (0..1) is the bonus weight for the roll after.
  - On an accepted roll: point += pins*(1+pend_a).
  - Strike in frame <FRAMES: pend_a<=pend_b+1, pend_b<=1.
  - Spare in frame <FRAMES: pend_a<=pend_b+1, pend_b<=0.
  - Otherwise, including every roll in frame FRAMES: pend_a<=pend_b, pend_b<=0.
  - Multiply is by 1/2/3 only; implement as shift-add. Adder width SCORE_W, no wrap possible with legal input.
- Illegal roll (pins>PINS, or pins>standing where standing applies): no state, score or bonus change; illegal pulses.
- roll_no reads 1/2/3 per state (S_X2=2, S_X3=3). frame_no holds FRAMES in S_DONE.

Optional Feature:
Macro BOWL_ILLEGAL_CLAMP_EN.
- Defined: an illegal roll is clamped to the current legal maximum (standing, or PINS in S_R1/S_X2) and accepted as that value. Both illegal and score_upd pulse.
- Undefined: illegal rolls are rejected as described above.

Decomposition:
- Package bowl_pkg holds: state enum (S_R1, S_R2, S_X2, S_X3, S_DONE), PINS/FRAMES/SCORE_W defaults, and the max-score constant 300.
- One sub-module, bowl_roll_check: combinational legality and clamp. Inputs are state, standing and roll_pins. Outputs are legal, the effective pins value, is_strike and is_spare.
- Scoring, bonus counters and FSM stay in bowling_score_keeper.

Test Plan:
- Perfect game, 12 rolls of 10 -> point 300; game_over after 12th roll; roll_no 3 on the final roll; 13th roll ignored, no illegal pulse.
- 20 rolls of 0 -> point 0; game_over after 20th roll; score_upd pulses 20 times.
- 21 rolls of 5 (all spares) -> point 150; frame 10 enters S_X3, then S_DONE.
- Frames 1-9 as 9,0, frame 10 as 3,4 -> point 88; game_over after roll 20; no third roll accepted.
- Roll 7 then 5 in frame 1 -> illegal pulse, point stays 7, roll_no stays 2. Then roll 3 -> point 10, frame_no 2. With BOWL_ILLEGAL_CLAMP_EN: the 5 is clamped to 3, frame 1 closes as a spare.
- Strikes in frames 1-3, then rst asserted together with roll_valid (pins 10) -> point 0, frame_no 1, roll ignored. Next roll 4 -> point 4.
